// File: rtl/imem_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : imem_loader_pkg
// Purpose  : Shared state encoding and word-geometry constants for imem_loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

  localparam int IMEM_WIDTH = 32;

  function automatic int idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

  localparam int BYTES_PER_WORD = IMEM_WIDTH / 8;
  localparam int BYTE_IDX_W     = idx_width(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    BYTES  = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_word_assembler.sv
//------------------------------------------------------------------------------
// Module   : imem_word_assembler
// Purpose  : Packs a byte stream LSB-first into one instruction word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = IMEM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic             word_full
);

  localparam int LANES = WIDTH / 8;
  localparam int IDX_W = idx_width(LANES);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_word;

  assign word_full = load && (r_idx == C_LAST_IDX);
  assign word      = r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (load) begin
      r_word[8*r_idx +: 8] <= byte_in;
      r_idx <= word_full ? '0 : r_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// Module   : imem_loader
// Purpose  : Streams bytes into the instruction memory while holding the CPU.
//            Optional trailing-byte XOR check: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH  = IMEM_WIDTH,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              error
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic              w_ready;
  logic              w_xfer;
  logic              w_hdr_xfer;
  logic              w_data_xfer;
  logic              w_word_full;
  logic              w_last_word;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last_idx;

  // Ready depends only on the state register so the handshake has no comb loop.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign w_ready = (r_state == HEADER) || (r_state == BYTES) || (r_state == CHECK);
`else
  assign w_ready = (r_state == HEADER) || (r_state == BYTES);
`endif

  assign byte_ready  = w_ready;
  assign w_xfer      = byte_valid && w_ready;
  assign w_hdr_xfer  = w_xfer && (r_state == HEADER);
  assign w_data_xfer = w_xfer && (r_state == BYTES);
  assign w_last_word = (r_addr == r_last_idx);
  assign busy        = (r_state != IDLE);
  assign cpu_hold    = busy;
  assign mem_addr    = r_addr;

  imem_word_assembler #(
    .WIDTH (WIDTH)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_hdr_xfer),
    .load      (w_data_xfer),
    .byte_in   (byte_data),
    .word      (mem_wdata),
    .word_full (w_word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_last_idx <= '0;
    end else if (w_hdr_xfer) begin
      r_addr     <= '0;
      r_last_idx <= byte_data[ADDR_W-1:0];
    end else if ((r_state == WRITE) && !w_last_word) begin
      r_addr <= r_addr + 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if (w_hdr_xfer) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if (w_data_xfer) begin
      r_csum <= r_csum ^ byte_data;
    end else if (w_xfer && (r_state == CHECK) && (byte_data != r_csum)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`endif

  always_comb begin
    w_next = r_state;
    mem_we = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = HEADER;
      end
      HEADER: begin
        if (w_xfer) w_next = BYTES;
      end
      BYTES: begin
        if (w_word_full) w_next = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = BYTES;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_xfer) w_next = DONE;
      end
`endif
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_loader
// Purpose  : Randomized self-checking bench for imem_loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        error;
`endif

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .error      (error)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  img [0:255];
  logic [31:0] mem_seen [0:63];
  int          wr_count = 0;

  // Memory image as seen on the write port.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_we === 1'b1) begin
      mem_seen[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit noise);
    bit sent = 1'b0;
    for (int t = 0; t < 64 && !sent; t++) begin
      byte_valid = (t == 63) || (int'($urandom_range(99)) >= gap_pct);
      byte_data  = byte_valid ? b : 8'($urandom);
      start      = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check_eq("ready_hi", byte_ready, 1);
      check_eq("hold_hi", cpu_hold, 1);
      check_eq("no_write", mem_we, 0);
      sent = byte_valid && byte_ready;
      next_cycle();
    end
    if (!sent) check_eq("byte_timeout", 0, 1);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // Reference load: words come from img[], addresses count up from 0.
  task automatic do_load(input logic [5:0] last, input int gap_pct, input bit noise,
                         input int abort_words, input logic [7:0] flip);
    logic [31:0] word;
    logic [7:0]  csum;
    start      = 1'b1;
    byte_valid = 1'($urandom);
    byte_data  = 8'($urandom);
    @(negedge clk);
    check_eq("idle_ready", byte_ready, 0);
    check_eq("idle_hold", cpu_hold, 0);
    next_cycle();
    start = 1'b0;
    send_byte({2'($urandom), last}, gap_pct, noise);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_eq("err_clr", error, 0);
`endif
    csum = 8'h00;
    for (int w = 0; w <= int'(last); w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        word = word | (32'(img[w*4+k]) << (8*k));
        csum = csum ^ img[w*4+k];
        send_byte(img[w*4+k], gap_pct, noise);
      end
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      start      = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check_eq("we", mem_we, 1);
      check_eq("addr", mem_addr, w);
      check_eq("wdata", mem_wdata, word);
      check_eq("write_ready", byte_ready, 0);
      next_cycle();
      start = 1'b0;
      if (w + 1 == abort_words) begin
        rst        = 1'b1;
        byte_valid = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_eq("abort_hold", cpu_hold, 0);
        check_eq("abort_busy", busy, 0);
        for (int c = 0; c < 20; c++) begin
          byte_data = 8'($urandom);
          @(negedge clk);
          check_eq("abort_no_we", mem_we, 0);
          next_cycle();
        end
        byte_valid = 1'b0;
        return;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum ^ flip, gap_pct, 1'b0);
`endif
    start      = 1'b0;
    byte_valid = 1'($urandom);
    byte_data  = 8'($urandom);
    @(negedge clk);
    check_eq("done", done, 1);
    check_eq("done_hold", cpu_hold, 1);
    check_eq("done_no_we", mem_we, 0);
    next_cycle();
    byte_valid = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("hold_drop", cpu_hold, 0);
    check_eq("busy_drop", busy, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_eq("err_sticky", error, (flip != 8'h00) ? 1 : 0);
`else
    check_eq("flip_unused", 32'(flip) & 32'h0, 0);
`endif
    next_cycle();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    int base;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_ready", byte_ready, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_hold", cpu_hold, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_eq("rst_error", error, 0);
`endif
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("idle_no_ready", byte_ready, 0);
      check_eq("idle_no_hold", cpu_hold, 0);
      next_cycle();
    end
    byte_valid = 1'b0;

    // Single word
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h10; img[3] = 8'h00;
    base = wr_count;
    do_load(6'd0, 0, 1'b0, -1, 8'h00);
    check_eq("single_count", wr_count - base, 1);
    check_eq("single_word", mem_seen[0], 32'h00100513);

    // Full depth with 50% gaps
    fill_random();
    base = wr_count;
    do_load(6'd63, 50, 1'b0, -1, 8'h00);
    check_eq("full_count", wr_count - base, 64);
    for (int w = 0; w < 64; w++)
      check_eq("full_mem", mem_seen[w], {img[w*4+3], img[w*4+2], img[w*4+1], img[w*4]});

    // start pulses while busy
    fill_random();
    base = wr_count;
    do_load(6'd7, 30, 1'b1, -1, 8'h00);
    check_eq("noise_count", wr_count - base, 8);

    // Reset after two words, then a clean reload
    fill_random();
    base = wr_count;
    do_load(6'd7, 20, 1'b0, 2, 8'h00);
    check_eq("abort_count", wr_count - base, 2);
    fill_random();
    base = wr_count;
    do_load(6'd3, 10, 1'b0, -1, 8'h00);
    check_eq("reload_count", wr_count - base, 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h04; img[3] = 8'h08;
    do_load(6'd0, 0, 1'b0, -1, 8'h00);
    do_load(6'd0, 0, 1'b0, -1, 8'h01);
    fill_random();
    do_load(6'd2, 25, 1'b0, -1, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the 64-entry instruction memory. The block takes a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It issues one write per word into the instruction memory write port, starting at address 0. The CPU is held stalled for the whole load, so the processor can be reprogrammed at runtime without reloading the hex file.

Parameters:
WIDTH, 32, instruction word width; must be a multiple of 8
ADDR_W, 6, instruction memory address width
BYTES_PER_WORD, WIDTH/8, bytes assembled per word (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a new load; sampled only in IDLE
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts byte_data this cycle
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_W  write address
mem_wdata  out  WIDTH  write data
cpu_hold  out  1  stall or hold the CPU while high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a load completes
error  out  1  sticky checksum error; exists only with the optional feature

Behaviour:
- Reset value of every output is 0. Reset also clears the internal counters, the assembly register and the checksum accumulator, and forces the state to IDLE.
- A byte transfer occurs on a cycle where byte_valid and byte_ready are both high. byte_data is ignored on all other cycles. byte_valid may drop at any time without penalty.
- IDLE: byte_ready=0 and cpu_hold=0. When start=1, go to HEADER and set cpu_hold=1 on the next cycle.
- HEADER: byte_ready=1. On a transfer, latch last_idx = byte_data[ADDR_W-1:0] (word count minus 1) and ignore the upper bits. Clear the word address to 0 and go to BYTES.
- BYTES: byte_ready=1. Bytes fill the word LSB first: byte k lands in bits [8k+7:8k]. When byte BYTES_PER_WORD-1 transfers, go to WRITE.
- WRITE: byte_ready=0. For exactly one cycle: mem_we=1, mem_addr=current address, mem_wdata=assembled word. The write therefore lands one cycle after the last byte handshake.
  - If address==last_idx, go to CHECK (feature on) or DONE (feature off).
  - Otherwise increment the address and return to BYTES.
- DONE: done=1 for one cycle, cpu_hold drops on the next cycle, then go to IDLE.
- start is ignored outside IDLE. A start held high through DONE begins a new load from the following IDLE cycle.
- last_idx=63 loads all 64 words. The address never wraps within one load.
- Reset mid-load: immediate return to IDLE with cpu_hold=0. Words already written stay in memory and no rollback is performed.
- mem_addr and mem_wdata are don't-care when mem_we=0, but they must be driven from registers.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- With the macro defined:
  - A running XOR of all data bytes (header excluded) is kept, cleared on the HEADER transfer.
  - The CHECK state has byte_ready=1 and accepts one trailing byte. A mismatch sets error=1. error stays set until the next HEADER transfer or reset.
  - The load proceeds to DONE whether or not the checksum matches.
- Without the macro: no CHECK state, no error port, no trailing byte.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, HEADER, BYTES, WRITE, CHECK, DONE);
  - localparam BYTES_PER_WORD;
  - the byte-index counter width, $clog2(BYTES_PER_WORD).
- One natural sub-module: imem_word_assembler. It holds the byte index counter and the little-endian packing register, and exposes load/clear/word_full.

Test Plan:
- Reset: assert rst for 2 cycles with byte_valid=1 -> every output is 0 and byte_ready stays 0 until start.
- Single word: start, header 0x00, bytes 13 05 10 00 -> one mem_we pulse with mem_addr=0 and mem_wdata=0x00100513 one cycle after the 4th byte. done pulses, and cpu_hold spans from the cycle after start to the cycle after done.
- Full depth with gaps: header 0x3F, 256 bytes with byte_valid randomly low 50% of the time -> 64 writes at addresses 0..63 in order with correct data, and no extra write.
- Busy start: pulse start during BYTES -> no restart; the address sequence and data are unaffected.
- Reset mid-load: rst after word 2 of header 0x07 -> cpu_hold=0 next cycle. Words 0-1 are written and no further mem_we occurs. A new start loads correctly from address 0.
- Checksum (macro on): header 0x00, bytes 01 02 04 08, trailer 0x0F -> error=0. Repeat with trailer 0x0E -> error=1, still sticky after done, and cleared by the next HEADER transfer.
